// File: rtl/clq_result_collector_pkg.sv
// Shared widths and FSM state encoding for the clique result collector.
package clq_result_collector_pkg;

  localparam int VW_DEF    = 10;   // vertex index width
  localparam int SW_DEF    = 5;    // clique size width
  localparam int DEPTH_DEF = 128;  // vertex store entries
  localparam int CW_DEF    = 16;   // clique counter width

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

endpackage

// File: rtl/clq_result_collector_if.sv
// Clique result stream: one contiguous valid burst per clique, one vertex per beat.
interface clq_result_collector_if #(
  parameter int VW = 10,
  parameter int SW = 5
);
  logic          clq_valid;
  logic [SW-1:0] clq_size;
  logic [VW-1:0] clq_v;

  modport master (output clq_valid, clq_size, clq_v);
  modport slave  (input  clq_valid, clq_size, clq_v);
endinterface

// File: rtl/clq_result_collector_store_ram.sv
// Simple dual-port vertex store: one write port, one registered read port.
// Read-before-write: a same-cycle write to the read address returns old data.
module clq_result_collector_store_ram #(
  parameter int VW    = 10,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [VW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [VW-1:0] rdata_o
);

  logic [VW-1:0] mem_q [DEPTH];
  logic [VW-1:0] rdata_q;

  // Write port and registered read port; no reset so the array maps to RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/clq_result_collector.sv
// Sink for the max-clique result stream: tracks the running maximum size,
// counts cliques of that size and buffers their vertex lists for readback.
module clq_result_collector
  import clq_result_collector_pkg::*;
#(
  parameter int VW    = VW_DEF,
  parameter int SW    = SW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic [SW-1:0]         i_init_maxsize,
  clq_result_collector_if.slave clq_i,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [VW-1:0]         o_rd_data,
  output logic [SW-1:0]         o_maxsize,
  output logic [CW-1:0]         o_n_cliques,
  output logic [AW:0]           o_n_stored,
  output logic                  o_overflow,
  output logic                  o_len_err,
  output logic                  o_busy
);

  // Beat counter is one bit wider than the size field and saturates, so an
  // overlong burst can never wrap back onto its sampled target length.
  localparam int BW = SW + 1;
  localparam logic [AW:0]   NST_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] NCL_ONE  = CW'(1);
  localparam logic [BW-1:0] BCNT_ONE = BW'(1);

  state_e        state_q;
  logic [SW-1:0] maxsize_q;
  logic [CW-1:0] ncl_q;
  logic [AW:0]   nst_q;
  logic          ovf_q;
  logic          lerr_q;
  logic [SW-1:0] len_tgt_q;
  logic [BW-1:0] bcnt_q;
  logic          rd_ok_q;

  logic          full;
  logic          new_max;
  logic          eq_max;
  logic          wr_en_d;
  logic [AW-1:0] wr_addr_d;
  logic [VW-1:0] ram_rdata;

  // nst_q never exceeds DEPTH, so the top bit alone marks a full store.
  assign full    = nst_q[AW];
  assign new_max = clq_i.clq_size >  maxsize_q;
  assign eq_max  = clq_i.clq_size == maxsize_q;

  // Store write strobe: first beat of a new maximum rewinds to entry 0,
  // otherwise append at the fill pointer while room remains.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = nst_q[AW-1:0];
    if (!i_reset && !i_clear && clq_i.clq_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (new_max) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
          end else if (eq_max) begin
            wr_en_d   = !full;
          end
        end
        S_CAPTURE: wr_en_d = !full;
        default:   wr_en_d = 1'b0;
      endcase
    end
  end

  // Burst FSM with registered status; clear beats any beat in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      maxsize_q <= '0;
      ncl_q     <= '0;
      nst_q     <= '0;
      ovf_q     <= 1'b0;
      lerr_q    <= 1'b0;
      len_tgt_q <= '0;
      bcnt_q    <= '0;
    end else if (i_clear) begin
      maxsize_q <= i_init_maxsize;
      ncl_q     <= '0;
      nst_q     <= '0;
      ovf_q     <= 1'b0;
      lerr_q    <= 1'b0;
      // Any burst still on the wire belongs to the old problem.
      state_q   <= clq_i.clq_valid ? S_DISCARD : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (clq_i.clq_valid) begin
            len_tgt_q <= clq_i.clq_size;
            bcnt_q    <= BCNT_ONE;
            if (new_max) begin
              maxsize_q <= clq_i.clq_size;
              ncl_q     <= NCL_ONE;
              nst_q     <= NST_ONE;
              ovf_q     <= 1'b0;
              state_q   <= S_CAPTURE;
            end else if (eq_max) begin
              if (ncl_q != '1) ncl_q <= ncl_q + NCL_ONE;
              if (full) ovf_q <= 1'b1;
              else      nst_q <= nst_q + NST_ONE;
              state_q <= S_CAPTURE;
            end else begin
              state_q <= S_DISCARD;
            end
          end
        end
        S_CAPTURE: begin
          if (clq_i.clq_valid) begin
            if (full) ovf_q <= 1'b1;
            else      nst_q <= nst_q + NST_ONE;
            if (bcnt_q != '1) bcnt_q <= bcnt_q + BCNT_ONE;
          end else begin
            if (bcnt_q != {1'b0, len_tgt_q}) lerr_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_DISCARD: begin
          if (!clq_i.clq_valid) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Qualify the RAM read so unwritten or stale entries read back as zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) rd_ok_q <= 1'b0;
    else         rd_ok_q <= {1'b0, i_rd_addr} < nst_q;
  end

  clq_result_collector_store_ram #(
    .VW    (VW),
    .DEPTH (DEPTH)
  ) u_store (
    .clk_i   (i_clk),
    .we_i    (wr_en_d),
    .waddr_i (wr_addr_d),
    .wdata_i (clq_i.clq_v),
    .raddr_i (i_rd_addr),
    .rdata_o (ram_rdata)
  );

  assign o_rd_data   = rd_ok_q ? ram_rdata : '0;
  assign o_maxsize   = maxsize_q;
  assign o_n_cliques = ncl_q;
  assign o_n_stored  = nst_q;
  assign o_overflow  = ovf_q;
  assign o_len_err   = lerr_q;
  assign o_busy      = state_q != S_IDLE;

endmodule

// File: tb/tb_clq_result_collector.sv
// Bench for clq_result_collector: a burst-level reference model predicts the
// status registers and store contents; readback expectations go through a queue.
module tb_clq_result_collector;

  localparam int VW    = 10;
  localparam int SW    = 5;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_clear;
  logic [SW-1:0] i_init_maxsize;
  logic [AW-1:0] i_rd_addr;
  logic [VW-1:0] o_rd_data;
  logic [SW-1:0] o_maxsize;
  logic [CW-1:0] o_n_cliques;
  logic [AW:0]   o_n_stored;
  logic          o_overflow;
  logic          o_len_err;
  logic          o_busy;

  always #5 i_clk = ~i_clk;

  clq_result_collector_if #(.VW(VW), .SW(SW)) clq_if ();

  clq_result_collector #(
    .VW(VW), .SW(SW), .DEPTH(DEPTH), .CW(CW)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_clear        (i_clear),
    .i_init_maxsize (i_init_maxsize),
    .clq_i          (clq_if.slave),
    .i_rd_addr      (i_rd_addr),
    .o_rd_data      (o_rd_data),
    .o_maxsize      (o_maxsize),
    .o_n_cliques    (o_n_cliques),
    .o_n_stored     (o_n_stored),
    .o_overflow     (o_overflow),
    .o_len_err      (o_len_err),
    .o_busy         (o_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int beats[$];

  // reference model state
  int m_max, m_ncl, m_nst, m_ovf, m_lerr;
  int m_mem[DEPTH];

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    chk({tag, ".maxsize"}, int'(o_maxsize),   m_max);
    chk({tag, ".ncl"},     int'(o_n_cliques), m_ncl);
    chk({tag, ".nst"},     int'(o_n_stored),  m_nst);
    chk({tag, ".ovf"},     int'(o_overflow),  m_ovf);
    chk({tag, ".lerr"},    int'(o_len_err),   m_lerr);
    chk({tag, ".busy"},    int'(o_busy),      0);
  endtask

  task automatic model_clear(input int init);
    m_max = init; m_ncl = 0; m_nst = 0; m_ovf = 0; m_lerr = 0;
  endtask

  // whole-burst view of the recording rules
  task automatic model_burst(input int sz);
    bit rec;
    rec = 1'b0;
    if (sz > m_max) begin
      m_max = sz; m_ncl = 1; m_nst = 0; m_ovf = 0; rec = 1'b1;
    end else if (sz == m_max) begin
      if (m_ncl < (1 << CW) - 1) m_ncl++;
      rec = 1'b1;
    end
    if (rec) begin
      foreach (beats[i]) begin
        if (m_nst < DEPTH) begin
          m_mem[m_nst] = beats[i];
          m_nst++;
        end else begin
          m_ovf = 1;
        end
      end
      if (beats.size() != sz) m_lerr = 1;
    end
  endtask

  task automatic do_clear(input int init);
    i_init_maxsize = SW'(init);
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    model_clear(init);
  endtask

  task automatic send_burst(input string tag, input int sz);
    foreach (beats[i]) begin
      clq_if.clq_valid = 1'b1;
      clq_if.clq_size  = SW'(sz);
      clq_if.clq_v     = VW'(beats[i]);
      tick();
      chk({tag, ".busy_in"}, int'(o_busy), 1);
    end
    clq_if.clq_valid = 1'b0;
    tick();
    model_burst(sz);
    check_status(tag);
  endtask

  task automatic rd_check(input int a);
    i_rd_addr = AW'(a);
    exp_q.push_back((a < m_nst) ? m_mem[a] : 0);
    tick();
    chk($sformatf("rd[%0d]", a), int'(o_rd_data), exp_q.pop_front());
  endtask

  initial begin
    i_reset = 1'b1; i_clear = 1'b0; i_init_maxsize = '0; i_rd_addr = '0;
    clq_if.clq_valid = 1'b0; clq_if.clq_size = '0; clq_if.clq_v = '0;
    model_clear(0);
    tick(); tick();
    i_reset = 1'b0;
    check_status("reset");
    chk("reset.rd", int'(o_rd_data), 0);

    // first maximum, then a tie, then a smaller clique that is ignored
    do_clear(3);
    check_status("clear3");
    beats = '{5, 9, 12, 30};  send_burst("b4a", 4);
    for (int a = 0; a < 4; a++) rd_check(a);
    beats = '{1, 2, 3, 4};    send_burst("b4b", 4);
    beats = '{7, 8};          send_burst("b2", 2);
    for (int a = 4; a < 8; a++) rd_check(a);

    // larger maximum rewinds the store
    beats = '{10, 11, 12, 13, 14}; send_burst("b5", 5);
    rd_check(0);
    rd_check(4);
    rd_check(5);

    // overflow on the ninth beat, cleared by a new maximum
    do_clear(1);
    beats = '{21, 22, 23}; send_burst("ov1", 3);
    beats = '{24, 25, 26}; send_burst("ov2", 3);
    beats = '{27, 28, 29}; send_burst("ov3", 3);
    rd_check(7);
    beats = '{40, 41, 42, 43}; send_burst("ov4", 4);
    rd_check(3);

    // length error is sticky across later good bursts until clear
    do_clear(1);
    beats = '{1, 2, 3, 4}; send_burst("len1", 3);
    beats = '{5, 6, 7};    send_burst("len2", 3);
    do_clear(1);
    check_status("len_clr");

    // size-0 clique at a zero threshold is recorded and flagged
    do_clear(0);
    beats = '{99}; send_burst("sz0", 0);
    rd_check(0);

    // clear on beat 2 of a 4-beat burst
    do_clear(2);
    beats = '{1, 2, 3, 4}; send_burst("pre", 4);
    clq_if.clq_size = SW'(4);
    clq_if.clq_valid = 1'b1; clq_if.clq_v = VW'(50); tick();
    clq_if.clq_v = VW'(51); i_init_maxsize = SW'(2); i_clear = 1'b1; tick();
    i_clear = 1'b0; model_clear(2);
    clq_if.clq_v = VW'(52); tick();
    chk("clrmid.busy3", int'(o_busy), 1);
    clq_if.clq_v = VW'(53); tick();
    chk("clrmid.busy4", int'(o_busy), 1);
    clq_if.clq_valid = 1'b0; tick();
    check_status("clrmid");
    rd_check(0);

    // reset mid-burst
    do_clear(1);
    clq_if.clq_size = SW'(3);
    clq_if.clq_valid = 1'b1; clq_if.clq_v = VW'(60); tick();
    clq_if.clq_v = VW'(61); tick();
    i_reset = 1'b1; clq_if.clq_v = VW'(62); tick();
    i_reset = 1'b0; clq_if.clq_valid = 1'b0;
    model_clear(0);
    check_status("rstmid");
    chk("rstmid.rd", int'(o_rd_data), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
